// File: rtl/fp_op_sequencer_if.sv
// Request/response handshake bundle between a client and the FP op sequencer.
// The master drives requests and accepts responses; the slave is the sequencer.
interface fp_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_mode_fp;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_flags;

  modport master (
    output req_valid, req_mode_fp, req_op, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_flags
  );

  modport slave (
    input  req_valid, req_mode_fp, req_op, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_flags
  );
endinterface

// File: rtl/fp_op_sequencer.sv
// Front-end controller for the shared FP unit: latches one operation, resolves
// IEEE-754 special cases locally, otherwise launches the unit and guards it with a watchdog.
module fp_op_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  fp_op_sequencer_if.slave    bus,
  output logic                dec_mode_fp,
  output logic [31:0]         dec_a,
  output logic [31:0]         dec_b,
  input  logic                dec_sign_a,
  input  logic                dec_sign_b,
  input  logic                dec_is_nan_a,
  input  logic                dec_is_nan_b,
  input  logic                dec_is_inf_a,
  input  logic                dec_is_inf_b,
  input  logic                dec_is_zero_a,
  input  logic                dec_is_zero_b,
  output logic                unit_start,
  output logic [1:0]          unit_op,
  input  logic                unit_done,
  input  logic [31:0]         unit_result,
  input  logic [4:0]          unit_flags,
  output logic                timeout_err
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [4:0] FLAG_INVALID = 5'b10000;
  localparam logic [4:0] FLAG_DIVZERO = 5'b01000;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wd_cnt;
  logic [31:0]      res_data_q;
  logic [4:0]       res_flags_q;

  logic        accept;
  logic        sign_b_eff;
  logic        addsub_invalid;
  logic        mul_invalid;
  logic        div_invalid;
  logic        div_by_zero;
  logic        special_hit;
  logic [31:0] special_data;
  logic [4:0]  special_flags;
  logic [31:0] qnan_val;
  logic [31:0] inf_val;
  logic        inf_sign;
  logic        timeout_hit;
  logic [31:0] unit_result_masked;

  assign bus.req_ready = (state == S_IDLE);
  assign bus.res_valid = (state == S_DONE);
  assign bus.res_data  = res_data_q;
  assign bus.res_flags = res_flags_q;

  assign accept = (state == S_IDLE) && bus.req_valid;

  // Subtraction is treated as addition of b with its sign flipped.
  assign sign_b_eff     = dec_sign_b ^ (unit_op == OP_SUB);
  assign addsub_invalid = ((unit_op == OP_ADD) || (unit_op == OP_SUB)) &&
                          dec_is_inf_a && dec_is_inf_b && (dec_sign_a != sign_b_eff);
  assign mul_invalid    = (unit_op == OP_MUL) &&
                          ((dec_is_inf_a && dec_is_zero_b) || (dec_is_zero_a && dec_is_inf_b));
  assign div_invalid    = (unit_op == OP_DIV) &&
                          ((dec_is_inf_a && dec_is_inf_b) || (dec_is_zero_a && dec_is_zero_b));
  assign div_by_zero    = (unit_op == OP_DIV) && dec_is_zero_b &&
                          !dec_is_inf_a && !dec_is_zero_a;

  assign inf_sign = dec_sign_a ^ dec_sign_b;
  assign qnan_val = dec_mode_fp ? 32'h7FC0_0000 : 32'h0000_7E00;
  assign inf_val  = dec_mode_fp ? {inf_sign, 8'hFF, 23'b0} : {16'b0, inf_sign, 5'h1F, 10'b0};

  assign unit_result_masked = dec_mode_fp ? unit_result : {16'b0, unit_result[15:0]};

  // Watchdog expiry: a done arriving on the final count cycle takes precedence.
  assign timeout_hit = (state == S_WAIT) && !unit_done && (wd_cnt == CNT_LAST);

  always_comb begin
    special_hit   = 1'b1;
    special_data  = qnan_val;
    special_flags = FLAG_INVALID;
    if (dec_is_nan_a || dec_is_nan_b) begin
      special_flags = 5'b0;
    end else if (addsub_invalid || mul_invalid || div_invalid) begin
      special_flags = FLAG_INVALID;
    end else if (div_by_zero) begin
      special_data  = inf_val;
      special_flags = FLAG_DIVZERO;
    end else begin
      special_hit   = 1'b0;
      special_data  = 32'b0;
      special_flags = 5'b0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = S_DECODE;
      S_DECODE: state_next = special_hit ? S_DONE : S_EXEC;
      S_EXEC:   state_next = S_WAIT;
      S_WAIT:   if (unit_done || timeout_hit) state_next = S_DONE;
      S_DONE:   if (bus.res_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_mode_fp <= 1'b0;
      dec_a       <= 32'b0;
      dec_b       <= 32'b0;
      unit_op     <= 2'b0;
      unit_start  <= 1'b0;
      wd_cnt      <= '0;
      res_data_q  <= 32'b0;
      res_flags_q <= 5'b0;
      timeout_err <= 1'b0;
    end else begin
      unit_start <= (state == S_DECODE) && !special_hit;

      if (accept) begin
        dec_mode_fp <= bus.req_mode_fp;
        dec_a       <= bus.req_a;
        dec_b       <= bus.req_b;
        unit_op     <= bus.req_op;
        timeout_err <= 1'b0;
      end

      if (state == S_EXEC) begin
        wd_cnt <= '0;
      end else if ((state == S_WAIT) && !unit_done && !timeout_hit) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end

      // Response registers only load on the transition into DONE, so they hold through backpressure.
      if ((state == S_DECODE) && special_hit) begin
        res_data_q  <= special_data;
        res_flags_q <= special_flags;
      end else if ((state == S_WAIT) && unit_done) begin
        res_data_q  <= unit_result_masked;
        res_flags_q <= unit_flags;
      end else if (timeout_hit) begin
        res_data_q  <= qnan_val;
        res_flags_q <= FLAG_INVALID;
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Scoreboard bench for fp_op_sequencer: behavioural decoder and FP unit models,
// directed requests push expected responses, a monitor pops them on each handshake.
module tb_fp_op_sequencer;
  localparam int TIMEOUT_CYCLES = 64;

  logic        clk;
  logic        rst_n;
  logic        dec_mode_fp;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic        dec_sign_a, dec_sign_b;
  logic        dec_is_nan_a, dec_is_nan_b;
  logic        dec_is_inf_a, dec_is_inf_b;
  logic        dec_is_zero_a, dec_is_zero_b;
  logic        unit_start;
  logic [1:0]  unit_op;
  logic        unit_done;
  logic [31:0] unit_result;
  logic [4:0]  unit_flags;
  logic        timeout_err;

  fp_op_sequencer_if bus ();

  fp_op_sequencer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(7)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .dec_mode_fp   (dec_mode_fp),
    .dec_a         (dec_a),
    .dec_b         (dec_b),
    .dec_sign_a    (dec_sign_a),
    .dec_sign_b    (dec_sign_b),
    .dec_is_nan_a  (dec_is_nan_a),
    .dec_is_nan_b  (dec_is_nan_b),
    .dec_is_inf_a  (dec_is_inf_a),
    .dec_is_inf_b  (dec_is_inf_b),
    .dec_is_zero_a (dec_is_zero_a),
    .dec_is_zero_b (dec_is_zero_b),
    .unit_start    (unit_start),
    .unit_op       (unit_op),
    .unit_done     (unit_done),
    .unit_result   (unit_result),
    .unit_flags    (unit_flags),
    .timeout_err   (timeout_err)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  flags;
    logic        terr;
  } exp_t;

  exp_t sb_q[$];
  int   total_cnt = 0;
  int   bad_cnt   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decoder model: returns {sign, nan, inf, zero}.
  function automatic logic [3:0] classify(input logic [31:0] x, input logic mode);
    logic s, emax, ezero, mnz;
    if (mode) begin
      s = x[31]; emax = &x[30:23]; ezero = ~|x[30:23]; mnz = |x[22:0];
    end else begin
      s = x[15]; emax = &x[14:10]; ezero = ~|x[14:10]; mnz = |x[9:0];
    end
    return {s, emax & mnz, emax & ~mnz, ezero & ~mnz};
  endfunction

  logic [3:0] cls_a, cls_b;
  assign cls_a = classify(dec_a, dec_mode_fp);
  assign cls_b = classify(dec_b, dec_mode_fp);
  assign {dec_sign_a, dec_is_nan_a, dec_is_inf_a, dec_is_zero_a} = cls_a;
  assign {dec_sign_b, dec_is_nan_b, dec_is_inf_b, dec_is_zero_b} = cls_b;

  // FP unit model: pulses done unit_delay cycles after the start pulse.
  logic        unit_respond = 1'b1;
  int          unit_delay   = 1;
  int          unit_cd      = 0;
  logic        model_done   = 1'b0;
  logic        force_done   = 1'b0;
  logic [31:0] unit_value   = 32'b0;
  logic [4:0]  unit_fvalue  = 5'b0;

  assign unit_done   = model_done | force_done;
  assign unit_result = unit_value;
  assign unit_flags  = unit_fvalue;

  always @(negedge clk) begin
    model_done = 1'b0;
    if (unit_start && unit_respond) begin
      unit_cd = unit_delay;
    end else if (unit_cd > 0) begin
      unit_cd = unit_cd - 1;
      if (unit_cd == 0) model_done = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act !== req) begin
      bad_cnt++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_response", bus.res_data, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("res_data", bus.res_data, e.data);
        checkOutput("res_flags", {27'b0, bus.res_flags}, {27'b0, e.flags});
        checkOutput("timeout_err", {31'b0, timeout_err}, {31'b0, e.terr});
      end
    end
  end

  task automatic pushExp(input logic [31:0] d, input logic [4:0] f, input logic t);
    exp_t e;
    e.data = d; e.flags = f; e.terr = t;
    sb_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic mode, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic expect_resp,
                               input logic [31:0] ed, input logic [4:0] ef, input logic et);
    int n;
    if (expect_resp) pushExp(ed, ef, et);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_mode_fp = mode; bus.req_op = op;
    bus.req_a = a; bus.req_b = b;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) checkOutput("accept_wait", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic waitRes(output int lat, output int starts, output int start_at);
    lat = 0; starts = 0; start_at = -1;
    while (!bus.res_valid && lat < 100) begin
      @(negedge clk);
      lat++;
      if (unit_start) begin
        starts++;
        start_at = lat;
      end
    end
    if (!bus.res_valid) checkOutput("response_wait", {31'b0, bus.res_valid}, 32'd1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
    checkOutput({tag, "_res_valid"}, {31'b0, bus.res_valid}, 32'd0);
    checkOutput({tag, "_res_data"}, bus.res_data, 32'd0);
    checkOutput({tag, "_res_flags"}, {27'b0, bus.res_flags}, 32'd0);
    checkOutput({tag, "_dec_a"}, dec_a, 32'd0);
    checkOutput({tag, "_dec_b"}, dec_b, 32'd0);
    checkOutput({tag, "_dec_mode"}, {31'b0, dec_mode_fp}, 32'd0);
    checkOutput({tag, "_unit_op"}, {30'b0, unit_op}, 32'd0);
    checkOutput({tag, "_unit_start"}, {31'b0, unit_start}, 32'd0);
    checkOutput({tag, "_timeout_err"}, {31'b0, timeout_err}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int lat, starts, start_at;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_mode_fp = 1'b0; bus.req_op = 2'b0;
    bus.req_a = 32'b0; bus.req_b = 32'b0; bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    rst_n = 1'b1;

    // Unit path, single add
    unit_value = 32'h4040_0000; unit_fvalue = 5'b0; unit_delay = 3;
    applyStimulus(1'b1, 2'b00, 32'h3F80_0000, 32'h4000_0000, 1'b1, 32'h4040_0000, 5'b0, 1'b0);
    waitRes(lat, starts, start_at);
    checkOutput("add_latency", lat, 32'd6);
    checkOutput("add_start_cnt", starts, 32'd1);
    checkOutput("add_start_at", start_at, 32'd2);

    // Half mul Inf*0: local invalid, no unit launch
    applyStimulus(1'b0, 2'b10, 32'h0000_7C00, 32'h0000_0000, 1'b1, 32'h0000_7E00, 5'b10000, 1'b0);
    waitRes(lat, starts, start_at);
    checkOutput("hmul_latency", lat, 32'd2);
    checkOutput("hmul_start_cnt", starts, 32'd0);

    // Single div 1/-0: -Inf, divzero
    applyStimulus(1'b1, 2'b11, 32'h3F80_0000, 32'h8000_0000, 1'b1, 32'hFF80_0000, 5'b01000, 1'b0);
    waitRes(lat, starts, start_at);
    checkOutput("div0_latency", lat, 32'd2);
    checkOutput("div0_start_cnt", starts, 32'd0);

    applyStimulus(1'b1, 2'b00, 32'h7FC0_0000, 32'h3F80_0000, 1'b1, 32'h7FC0_0000, 5'b0, 1'b0);
    waitRes(lat, starts, start_at);
    applyStimulus(1'b1, 2'b01, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 5'b10000, 1'b0);
    waitRes(lat, starts, start_at);
    applyStimulus(1'b0, 2'b11, 32'h0000_0000, 32'h0000_8000, 1'b1, 32'h0000_7E00, 5'b10000, 1'b0);
    waitRes(lat, starts, start_at);

    // +Inf + +Inf is not special: goes to the unit
    unit_value = 32'h7F80_0000; unit_fvalue = 5'b0; unit_delay = 1;
    applyStimulus(1'b1, 2'b00, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7F80_0000, 5'b0, 1'b0);
    waitRes(lat, starts, start_at);
    checkOutput("infadd_latency", lat, 32'd4);
    checkOutput("infadd_start_cnt", starts, 32'd1);

    // Half unit result has its upper half forced to zero
    unit_value = 32'hABCD_4000; unit_fvalue = 5'b00001; unit_delay = 2;
    applyStimulus(1'b0, 2'b00, 32'h0000_3C00, 32'h0000_3C00, 1'b1, 32'h0000_4000, 5'b00001, 1'b0);
    waitRes(lat, starts, start_at);
    checkOutput("hadd_latency", lat, 32'd5);

    // Done on the final watchdog cycle wins over the timeout
    unit_value = 32'h1234_5678; unit_fvalue = 5'b00101; unit_delay = TIMEOUT_CYCLES;
    applyStimulus(1'b1, 2'b10, 32'h3F80_0000, 32'h4000_0000, 1'b1, 32'h1234_5678, 5'b00101, 1'b0);
    waitRes(lat, starts, start_at);
    checkOutput("lastcnt_latency", lat, TIMEOUT_CYCLES + 3);

    // Watchdog timeout with late done pulses ignored
    @(posedge clk); #1 bus.res_ready = 1'b0;
    unit_respond = 1'b0;
    applyStimulus(1'b1, 2'b11, 32'h3F80_0000, 32'h4000_0000, 1'b1, 32'h7FC0_0000, 5'b10000, 1'b1);
    waitRes(lat, starts, start_at);
    checkOutput("timeout_latency", lat, TIMEOUT_CYCLES + 3);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    checkOutput("late_done_data", bus.res_data, 32'h7FC0_0000);
    checkOutput("late_done_valid", {31'b0, bus.res_valid}, 32'd1);
    checkOutput("late_done_terr", {31'b0, timeout_err}, 32'd1);
    @(posedge clk); #1 bus.res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    checkOutput("idle_done_valid", {31'b0, bus.res_valid}, 32'd0);
    checkOutput("idle_done_terr", {31'b0, timeout_err}, 32'd1);
    unit_respond = 1'b1;
    applyStimulus(1'b1, 2'b00, 32'h7FC0_0000, 32'h0, 1'b1, 32'h7FC0_0000, 5'b0, 1'b0);
    checkOutput("terr_cleared", {31'b0, timeout_err}, 32'd0);
    waitRes(lat, starts, start_at);

    // Backpressure, then back-to-back accept after the handshake
    @(posedge clk); #1 bus.res_ready = 1'b0;
    applyStimulus(1'b1, 2'b10, 32'h7F80_0000, 32'h0, 1'b1, 32'h7FC0_0000, 5'b10000, 1'b0);
    waitRes(lat, starts, start_at);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_data", bus.res_data, 32'h7FC0_0000);
      checkOutput("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    pushExp(32'h7F80_0000, 5'b01000, 1'b0);
    bus.res_ready = 1'b1; bus.req_valid = 1'b1; bus.req_mode_fp = 1'b1;
    bus.req_op = 2'b11; bus.req_a = 32'h4000_0000; bus.req_b = 32'h0;
    @(negedge clk);
    checkOutput("b2b_busy_ready", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk);
    checkOutput("b2b_idle_ready", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    waitRes(lat, starts, start_at);
    checkOutput("b2b_latency", lat, 32'd2);

    // Reset asserted while waiting on the unit
    unit_respond = 1'b0;
    applyStimulus(1'b1, 2'b01, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h0, 5'b0, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("pre_reset_ready", {31'b0, bus.req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_ready", {31'b0, bus.req_ready}, 32'd1);

    unit_respond = 1'b1; unit_value = 32'h4000_0000; unit_fvalue = 5'b0; unit_delay = 2;
    applyStimulus(1'b1, 2'b10, 32'h3F80_0000, 32'h4000_0000, 1'b1, 32'h4000_0000, 5'b0, 1'b0);
    waitRes(lat, starts, start_at);
    checkOutput("recover_latency", lat, 32'd5);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
